sp_sram_arb2: RTL

- Two-requester arbiter and sequencer for one 512x32 single-port SRAM wrapper (active-low wen, cs, 9-bit addr, 1-cycle read latency).
- Accepts read/write commands from two masters (e.g. AHB slave bridge and DMA) over valid/ready.
- Issues at most one SRAM access per cycle with round-robin fairness.
- Returns read data to the originating requester with a fixed 2-cycle latency from handshake.

---
 rtl/sp_sram_arb_pkg.sv | 22 ++
 rtl/sp_sram_arb2_rr_arb2.sv | 50 +++++
 rtl/sp_sram_arb2.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sp_sram_arb_pkg.sv
// Shared constants and types for the two-requester SRAM arbiter.
// The lock feature (SRAM_ARB_LOCK_EN) uses the state encoding and counter width helper.
package sp_sram_arb_pkg;

    localparam int ADDR_WIDTH_DEF = 9;
    localparam int DATA_WIDTH_DEF = 32;

    // Requester identifiers; also the encoding of last_grant.
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Width of the lock counter, wide enough to hold max_lock itself.
    function automatic int lock_cnt_width(input int max_lock);
        return $clog2(max_lock) + 1;
    endfunction

endpackage

// File: rtl/sp_sram_arb2_rr_arb2.sv
// rr_arb2: 2-way round-robin grant with a last_grant register.
// A tie goes to the requester that was not granted last; force_en restricts the grant
// to force_id only (used by the lock logic). last_grant updates when accept is high.
module rr_arb2
    import sp_sram_arb_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    input  logic force_en,
    input  logic force_id,
    output logic grant_valid,
    output logic grant_id
);

    logic last_grant;

    // Grant selection from the current valids, last winner and the force request.
    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = last_grant;
        if (force_en) begin
            grant_valid = (force_id == REQ0) ? valid0 : valid1;
            grant_id    = force_id;
        end else if (valid0 && valid1) begin
            grant_valid = 1'b1;
            grant_id    = ~last_grant;
        end else if (valid0) begin
            grant_valid = 1'b1;
            grant_id    = REQ0;
        end else if (valid1) begin
            grant_valid = 1'b1;
            grant_id    = REQ1;
        end
    end

    // Remember the winner of each accepted handshake; reset so the first tie goes to requester 0.
    // NOTE: state is assigned with <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_grant <= REQ1;
        end else if (accept) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/sp_sram_arb2.sv
// sp_sram_arb2: two-requester arbiter/sequencer for a 512x32 single-port SRAM.
// Commands handshake in cycle N, issue to the SRAM in N+1, read data returns in N+2.
// Optional grant locking is compiled in with the macro SRAM_ARB_LOCK_EN.
module sp_sram_arb2
    import sp_sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
`ifdef SRAM_ARB_LOCK_EN
    ,
    parameter int MAX_LOCK   = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_rvalid,
    output logic [DATA_WIDTH-1:0] req0_rdata,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_rvalid,
    output logic [DATA_WIDTH-1:0] req1_rdata,

`ifdef SRAM_ARB_LOCK_EN
    input  logic                  req0_lock,
    input  logic                  req1_lock,
`endif

    output logic                  sram_cs,
    output logic                  sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_data,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    logic                  grant_valid;
    logic                  grant_id;
    logic                  hs;
    logic                  force_en;
    logic                  force_id;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  rd_s1;
    logic                  id_s1;
    logic [DATA_WIDTH-1:0] rdata0_hold;
    logic [DATA_WIDTH-1:0] rdata1_hold;

    rr_arb2 u_arb (
        .clk         (clk),
        .rstn        (rstn),
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .accept      (hs),
        .force_en    (force_en),
        .force_id    (force_id),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Ready is the grant itself, suppressed while reset is asserted.
    assign req0_ready = rstn & grant_valid & (grant_id == REQ0);
    assign req1_ready = rstn & grant_valid & (grant_id == REQ1);
    assign hs         = req0_ready | req1_ready;

`ifdef SRAM_ARB_LOCK_EN
    localparam int LOCK_CW = lock_cnt_width(MAX_LOCK);

    arb_state_t         state_q, state_d;
    logic               lock_id_q, lock_id_d;
    logic [LOCK_CW-1:0] lock_cnt_q, lock_cnt_d;
    logic               grant_lock;

    assign grant_lock = (grant_id == REQ0) ? req0_lock : req1_lock;

    // Lock state register.
    // NOTE: reset is synchronous: it is only seen at a clk edge, so it sits inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ARB;
            lock_id_q  <= REQ0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_id_q  <= lock_id_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Enter LOCKED on a locked handshake; leave on lock release or once MAX_LOCK cycles are used.
    // The counter advances every locked cycle, granted or idle, so the other side cannot starve.
    always_comb begin
        state_d    = state_q;
        lock_id_d  = lock_id_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ARB: begin
                if (hs && grant_lock && (MAX_LOCK > 1)) begin
                    state_d    = LOCKED;
                    lock_id_d  = grant_id;
                    lock_cnt_d = LOCK_CW'(1);
                end
            end
            LOCKED: begin
                if ((lock_cnt_q == LOCK_CW'(MAX_LOCK - 1)) || (hs && !grant_lock)) begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    assign force_en = (state_q == LOCKED);
    assign force_id = lock_id_q;
`else
    assign force_en = 1'b0;
    assign force_id = REQ0;
`endif

    // Command fields of the granted requester.
    always_comb begin
        sel_write = req0_write;
        sel_addr  = req0_addr;
        sel_data  = req0_wdata;
        if (grant_id == REQ1) begin
            sel_write = req1_write;
            sel_addr  = req1_addr;
            sel_data  = req1_wdata;
        end
    end

    // Issue stage: one SRAM access in the cycle after a handshake; addr/data hold when idle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sram_cs   <= 1'b0;
            sram_wen  <= 1'b1;
            sram_addr <= '0;
            sram_data <= '0;
        end else begin
            sram_cs  <= hs;
            sram_wen <= hs ? ~sel_write : 1'b1;
            if (hs) begin
                sram_addr <= sel_addr;
                sram_data <= sel_data;
            end
        end
    end

    // Read-return pipeline: tag issued reads with their requester, pulse rvalid when sram_q is valid.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_s1       <= 1'b0;
            id_s1       <= REQ0;
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            rdata0_hold <= '0;
            rdata1_hold <= '0;
        end else begin
            rd_s1       <= hs & ~sel_write;
            id_s1       <= grant_id;
            req0_rvalid <= rd_s1 & (id_s1 == REQ0);
            req1_rvalid <= rd_s1 & (id_s1 == REQ1);
            if (req0_rvalid) rdata0_hold <= sram_q;
            if (req1_rvalid) rdata1_hold <= sram_q;
        end
    end

    // sram_q is only valid during the return cycle, so it is passed through then and held afterwards.
    assign req0_rdata = req0_rvalid ? sram_q : rdata0_hold;
    assign req1_rdata = req1_rvalid ? sram_q : rdata1_hold;

endmodule
